// File: rtl/nb_delta_stage.sv
// -----------------------------------------------------------------------------
// nb_delta_stage
//
// Purpose:
//   Consumer stage for a free-running incrementing counter. Each accepted sample
//   is compared with the previously accepted one. The stage produces the
//   modular delta, a wrap-around flag, a first-sample flag and an error flag.
//   The error flag is set when the delta differs from the expected STEP.
//   Results are queued in a 2-entry ready/valid buffer: E0 is the head that
//   drives out_*, and E1 is a skid entry. The producer is stalled only when
//   both entries are full.
//
// Parameters:
//   WIDTH  bit width of the sample, out_data_o and out_delta_o
//   STEP   expected increment between consecutive accepted samples (mod 2^WIDTH)
//
// Ports:
//   clk_i        clock, all state updates on the rising edge
//   rst_i        asynchronous active-high reset
//   in_valid_i   producer presents in_data_i
//   in_data_i    sampled counter value
//   in_ready_o   stage can accept (depends on buffer state only)
//   out_valid_o  head entry valid
//   out_ready_i  consumer takes the head entry
//   out_data_o   accepted sample held in the head entry
//   out_delta_o  (sample - previous sample) mod 2^WIDTH, 0 for the first sample
//   out_wrap_o   sample < previous sample (the counter wrapped)
//   out_first_o  first sample accepted since reset
//   out_err_o    delta differs from STEP (never set on the first sample)
// -----------------------------------------------------------------------------
module nb_delta_stage #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned STEP  = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   // producer side
   input  logic             in_valid_i,
   input  logic [WIDTH-1:0] in_data_i,
   output logic             in_ready_o,
   // consumer side
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] out_data_o,
   output logic [WIDTH-1:0] out_delta_o,
   output logic             out_wrap_o,
   output logic             out_first_o,
   output logic             out_err_o
);

   // STEP is reduced to the sample width, so the step comparison is modular.
   localparam logic [WIDTH-1:0] StepW = WIDTH'(STEP);

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic [WIDTH-1:0] delta;
      logic             wrap;
      logic             first;
      logic             err;
   } result_t;

   typedef enum logic [1:0] {
      StEmpty = 2'd0,
      StOne   = 2'd1,
      StTwo   = 2'd2
   } state_e;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_e           state_q, state_d;
   result_t          e0_q, e0_d;       // head entry, drives out_*
   result_t          e1_q, e1_d;       // skid entry, only meaningful in StTwo
   logic [WIDTH-1:0] prev_q, prev_d;
   logic             have_prev_q, have_prev_d;

   // ---------------------------------------------------------------------------
   // Handshakes
   // ---------------------------------------------------------------------------
   logic accept;
   logic pop;

   // in_ready depends on the registered state only. This keeps the input
   // handshake free of any combinational path from out_ready_i.
   assign in_ready_o  = (state_q != StTwo);
   assign out_valid_o = (state_q != StEmpty);

   assign accept = in_valid_i & in_ready_o;
   assign pop    = out_valid_o & out_ready_i;

   // ---------------------------------------------------------------------------
   // Delta computation for the sample being offered
   // ---------------------------------------------------------------------------
   result_t          res;
   logic [WIDTH-1:0] raw_delta;

   assign raw_delta = in_data_i - prev_q;

   always_comb begin
      res       = '0;
      res.data  = in_data_i;
      res.first = ~have_prev_q;
      if (have_prev_q) begin
         res.delta = raw_delta;
         res.wrap  = (in_data_i < prev_q);
         res.err   = (raw_delta != StepW);
      end
   end

   // Only a real transfer moves the reference sample. Offers that are stalled
   // or not valid leave prev untouched.
   always_comb begin
      prev_d      = prev_q;
      have_prev_d = have_prev_q;
      if (accept) begin
         prev_d      = in_data_i;
         have_prev_d = 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Output buffer FSM
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      e0_d    = e0_q;
      e1_d    = e1_q;
      unique case (state_q)
         StEmpty: begin
            if (accept) begin
               e0_d    = res;
               state_d = StOne;
            end
         end
         StOne: begin
            if (accept && pop) begin
               // Head leaves and the new result replaces it in the same cycle.
               e0_d = res;
            end else if (accept) begin
               e1_d    = res;
               state_d = StTwo;
            end else if (pop) begin
               state_d = StEmpty;
            end
         end
         StTwo: begin
            // in_ready_o is low here, so only a pop can occur.
            if (pop) begin
               e0_d    = e1_q;
               state_d = StOne;
            end
         end
         default: begin
            state_d = StEmpty;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= StEmpty;
         e0_q        <= '0;
         e1_q        <= '0;
         prev_q      <= '0;
         have_prev_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         e0_q        <= e0_d;
         e1_q        <= e1_d;
         prev_q      <= prev_d;
         have_prev_q <= have_prev_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs come straight from the registered head entry
   // ---------------------------------------------------------------------------
   assign out_data_o  = e0_q.data;
   assign out_delta_o = e0_q.delta;
   assign out_wrap_o  = e0_q.wrap;
   assign out_first_o = e0_q.first;
   assign out_err_o   = e0_q.err;

   // ---------------------------------------------------------------------------
   // Protocol properties
   // ---------------------------------------------------------------------------
   // A stalled head must hold its value and stay valid.
   property p_head_stable;
      @(posedge clk_i) disable iff (rst_i)
         (out_valid_o && !out_ready_i) |=> (out_valid_o && $stable(e0_q));
   endproperty
   a_head_stable : assert property (p_head_stable);

   // The buffer never takes a sample while both entries are occupied.
   property p_no_accept_full;
      @(posedge clk_i) disable iff (rst_i)
         (state_q == StTwo) |-> !accept;
   endproperty
   a_no_accept_full : assert property (p_no_accept_full);

endmodule

// File: tb/tb_nb_delta_stage.sv
// -----------------------------------------------------------------------------
// tb_nb_delta_stage
//
// Purpose:
//   Self-checking bench for nb_delta_stage (WIDTH=8, STEP=1). The expected
//   result is queued when a sample is accepted. It is popped and compared when
//   the DUT hands a result to the consumer.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_nb_delta_stage;

   typedef struct packed {
      logic [7:0] data;
      logic [7:0] delta;
      logic       wrap;
      logic       first;
      logic       err;
   } exp_t;

   typedef struct {
      bit         rst_before;
      logic [7:0] din;
      exp_t       exp;
   } vec_t;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [7:0] out_delta;
   logic       out_wrap;
   logic       out_first;
   logic       out_err;

   int         n_checks = 0;
   int         n_errors = 0;

   exp_t       sb[$];
   logic [7:0] model_prev = 8'd0;
   bit         model_have = 1'b0;

   nb_delta_stage #(
      .WIDTH(8),
      .STEP (1)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .in_valid_i (in_valid),
      .in_data_i  (in_data),
      .in_ready_o (in_ready),
      .out_valid_o(out_valid),
      .out_ready_i(out_ready),
      .out_data_o (out_data),
      .out_delta_o(out_delta),
      .out_wrap_o (out_wrap),
      .out_first_o(out_first),
      .out_err_o  (out_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic void chk(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic exp_t mk_exp(input logic [7:0] data, input logic [7:0] delta,
                                   input logic wrap, input logic first, input logic err);
      exp_t e;
      e.data  = data;
      e.delta = delta;
      e.wrap  = wrap;
      e.first = first;
      e.err   = err;
      return e;
   endfunction

   function automatic vec_t mk_vec(input bit r, input logic [7:0] din, input exp_t e);
      vec_t v;
      v.rst_before = r;
      v.din        = din;
      v.exp        = e;
      return v;
   endfunction

   // Reference behaviour for the stream tests, based on the last accepted sample.
   function automatic exp_t model_exp(input logic [7:0] d);
      logic [7:0] dl;
      if (!model_have) return mk_exp(d, 8'd0, 1'b0, 1'b1, 1'b0);
      dl = d - model_prev;
      return mk_exp(d, dl, d < model_prev, 1'b0, dl != 8'd1);
   endfunction

   // Consumer-side monitor. Inputs only change at posedge+1, so a pop seen
   // here completes on the next rising edge.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_output", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("out_data", 32'(out_data), 32'(e.data));
            chk("out_delta", 32'(out_delta), 32'(e.delta));
            chk("out_wrap", 32'(out_wrap), 32'(e.wrap));
            chk("out_first", 32'(out_first), 32'(e.first));
            chk("out_err", 32'(out_err), 32'(e.err));
         end
      end
   end

   // Called at posedge+1. Returns at posedge+1 of the accepting edge.
   task automatic send(input logic [7:0] d, input exp_t e);
      bit ok;
      ok       = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (in_ready) begin
            sb.push_back(e);
            model_prev = d;
            model_have = 1'b1;
            ok         = 1'b1;
            break;
         end
      end
      if (!ok) chk("accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_model(input logic [7:0] d);
      send(d, model_exp(d));
   endtask

   task automatic drain();
      for (int c = 0; c < 60; c++) begin
         if (sb.size() == 0) break;
         @(posedge clk);
         #1;
      end
      chk("drain_left", 32'(sb.size()), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      chk({tag, "_out_data"}, 32'(out_data), 32'd0);
      chk({tag, "_out_delta"}, 32'(out_delta), 32'd0);
      chk({tag, "_out_wrap"}, 32'(out_wrap), 32'd0);
      chk({tag, "_out_first"}, 32'(out_first), 32'd0);
      chk({tag, "_out_err"}, 32'(out_err), 32'd0);
   endtask

   // Called at posedge+1.
   task automatic do_reset();
      rst = 1'b1;
      #1;
      check_reset_outputs("rst");
      sb.delete();
      model_have = 1'b0;
      model_prev = 8'd0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   vec_t vecs[10];

   initial begin
      time t0;

      vecs[0] = mk_vec(1'b0, 8'd5,   mk_exp(8'd5,   8'd0, 1'b0, 1'b1, 1'b0));
      vecs[1] = mk_vec(1'b0, 8'd6,   mk_exp(8'd6,   8'd1, 1'b0, 1'b0, 1'b0));
      vecs[2] = mk_vec(1'b0, 8'd7,   mk_exp(8'd7,   8'd1, 1'b0, 1'b0, 1'b0));
      vecs[3] = mk_vec(1'b1, 8'd254, mk_exp(8'd254, 8'd0, 1'b0, 1'b1, 1'b0));
      vecs[4] = mk_vec(1'b0, 8'd255, mk_exp(8'd255, 8'd1, 1'b0, 1'b0, 1'b0));
      vecs[5] = mk_vec(1'b0, 8'd0,   mk_exp(8'd0,   8'd1, 1'b1, 1'b0, 1'b0));
      vecs[6] = mk_vec(1'b0, 8'd1,   mk_exp(8'd1,   8'd1, 1'b0, 1'b0, 1'b0));
      vecs[7] = mk_vec(1'b1, 8'd10,  mk_exp(8'd10,  8'd0, 1'b0, 1'b1, 1'b0));
      vecs[8] = mk_vec(1'b0, 8'd13,  mk_exp(8'd13,  8'd3, 1'b0, 1'b0, 1'b1));
      vecs[9] = mk_vec(1'b0, 8'd14,  mk_exp(8'd14,  8'd1, 1'b0, 1'b0, 1'b0));

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 8'd0;
      out_ready = 1'b1;
      #2;
      check_reset_outputs("init");
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Basic stream, wrap-around, and step error with recovery.
      foreach (vecs[i]) begin
         if (vecs[i].rst_before) begin
            drain();
            do_reset();
         end
         send(vecs[i].din, vecs[i].exp);
      end
      drain();

      // Back-pressure: two entries fill, then in_ready drops and the head holds.
      do_reset();
      out_ready = 1'b0;
      send_model(8'd1);
      send_model(8'd2);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_out_data", 32'(out_data), 32'd1);
         chk("bp_out_first", 32'(out_first), 32'd1);
      end
      @(posedge clk);
      #1;
      fork
         send_model(8'd3);
         begin
            repeat (2) @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();

      // Full throughput: accept and pop each cycle while in state ONE.
      do_reset();
      t0 = $time;
      for (int k = 0; k < 16; k++) send_model(8'(k));
      chk("throughput_time", 32'($time - t0), 32'd160);
      drain();

      // Asynchronous reset with both entries occupied.
      out_ready = 1'b0;
      send_model(8'd20);
      send_model(8'd21);
      @(negedge clk);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      chk("full_out_valid", 32'(out_valid), 32'd1);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check_reset_outputs("async_rst");
      sb.delete();
      model_have = 1'b0;
      model_prev = 8'd0;
      @(posedge clk);
      #1;
      rst       = 1'b0;
      out_ready = 1'b1;
      send(8'd40, mk_exp(8'd40, 8'd0, 1'b0, 1'b1, 1'b0));
      send(8'd41, mk_exp(8'd41, 8'd1, 1'b0, 1'b0, 1'b0));
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got 1, expected 0");
      $fatal(1, "global timeout");
   end

endmodule
